rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the load/multi-cycle writeback. The block performs round-robin arbitration with a valid/ready handshake and registers the granted write onto the register file write port (write enable, write address, write data). It suppresses writes to x0. It also forwards the in-flight write to the decode-stage read addresses, because the register file commits on the clock edge after the write is presented.

---
 rtl/rf_write_arbiter.sv | 112 +++++++++++
 tb/tb_rf_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter sharing the register file write port between the ALU
// writeback (requester 0) and the load/multi-cycle writeback (requester 1).
// The granted write is registered onto the write port, writes to x0 are
// dropped after the handshake, and the in-flight write is forwarded to the
// two decode-stage read ports until the register file commits it.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              RF_WRITE,
    output logic [ADDR_W-1:0] RF_INADDRESS,
    output logic [DATA_W-1:0] RF_IN,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              FWD1_HIT,
    output logic [DATA_W-1:0] FWD1_DATA,
    output logic              FWD2_HIT,
    output logic [DATA_W-1:0] FWD2_DATA,
    output logic [CNT_W-1:0]  CONFLICT_CNT
);

    // Which requester wins when both are valid.
    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } pri_t;

    pri_t              r_pri;
    logic              r_rf_write;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic              w_ready0;
    logic              w_ready1;
    logic              w_xfer;
    logic              w_both;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_commit;
    logic              w_fwd1_hit;
    logic              w_fwd2_hit;

    // Grant: a lone valid requester wins, ties go to the priority pointer;
    // nothing is granted while RESET is high.
    always_comb begin
        w_both     = REQ0_VALID & REQ1_VALID;
        w_ready0   = ~RESET & REQ0_VALID & (~REQ1_VALID | (r_pri == PRI_REQ0));
        w_ready1   = ~RESET & REQ1_VALID & (~REQ0_VALID | (r_pri == PRI_REQ1));
        w_xfer     = w_ready0 | w_ready1;
        w_sel_addr = w_ready1 ? REQ1_ADDR : REQ0_ADDR;
        w_sel_data = w_ready1 ? REQ1_DATA : REQ0_DATA;
        // x0 writes still complete the handshake but never reach the port.
        w_commit   = w_xfer & (w_sel_addr != '0);
    end

    // Forward the in-flight write; RF_INADDRESS is never 0 while RF_WRITE is
    // high, so a read of x0 cannot hit.
    always_comb begin
        w_fwd1_hit = r_rf_write & (RD1_ADDR == r_rf_addr);
        w_fwd2_hit = r_rf_write & (RD2_ADDR == r_rf_addr);
    end

    // Priority pointer, registered write port and saturating conflict counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pri          <= PRI_REQ0;
            r_rf_write     <= 1'b0;
            r_rf_addr      <= '0;
            r_rf_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_ready0) begin
                r_pri <= PRI_REQ1;
            end else if (w_ready1) begin
                r_pri <= PRI_REQ0;
            end
            r_rf_write <= w_commit;
            if (w_commit) begin
                r_rf_addr <= w_sel_addr;
                r_rf_data <= w_sel_data;
            end
            if (w_both && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign REQ0_READY   = w_ready0;
    assign REQ1_READY   = w_ready1;
    assign RF_WRITE     = r_rf_write;
    assign RF_INADDRESS = r_rf_addr;
    assign RF_IN        = r_rf_data;
    assign FWD1_HIT     = w_fwd1_hit;
    assign FWD1_DATA    = w_fwd1_hit ? r_rf_data : '0;
    assign FWD2_HIT     = w_fwd2_hit;
    assign FWD2_DATA    = w_fwd2_hit ? r_rf_data : '0;
    assign CONFLICT_CNT = r_conflict_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: table-driven cycle vectors plus directed
// sequences for counter saturation and reset during an in-flight write.
module tb_rf_write_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    logic              CLK;
    logic              RESET;
    logic              REQ0_VALID;
    logic [ADDR_W-1:0] REQ0_ADDR;
    logic [DATA_W-1:0] REQ0_DATA;
    logic              REQ0_READY;
    logic              REQ1_VALID;
    logic [ADDR_W-1:0] REQ1_ADDR;
    logic [DATA_W-1:0] REQ1_DATA;
    logic              REQ1_READY;
    logic              RF_WRITE;
    logic [ADDR_W-1:0] RF_INADDRESS;
    logic [DATA_W-1:0] RF_IN;
    logic [ADDR_W-1:0] RD1_ADDR;
    logic [ADDR_W-1:0] RD2_ADDR;
    logic              FWD1_HIT;
    logic [DATA_W-1:0] FWD1_DATA;
    logic              FWD2_HIT;
    logic [DATA_W-1:0] FWD2_DATA;
    logic [CNT_W-1:0]  CONFLICT_CNT;

    rf_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ0_VALID  (REQ0_VALID),
        .REQ0_ADDR   (REQ0_ADDR),
        .REQ0_DATA   (REQ0_DATA),
        .REQ0_READY  (REQ0_READY),
        .REQ1_VALID  (REQ1_VALID),
        .REQ1_ADDR   (REQ1_ADDR),
        .REQ1_DATA   (REQ1_DATA),
        .REQ1_READY  (REQ1_READY),
        .RF_WRITE    (RF_WRITE),
        .RF_INADDRESS(RF_INADDRESS),
        .RF_IN       (RF_IN),
        .RD1_ADDR    (RD1_ADDR),
        .RD2_ADDR    (RD2_ADDR),
        .FWD1_HIT    (FWD1_HIT),
        .FWD1_DATA   (FWD1_DATA),
        .FWD2_HIT    (FWD2_HIT),
        .FWD2_DATA   (FWD2_DATA),
        .CONFLICT_CNT(CONFLICT_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Register file model: commits on the edge after the write is presented,
    // gated by RESET.
    logic [DATA_W-1:0] rf_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    end
    always @(posedge CLK) begin
        if (RF_WRITE && !RESET) rf_mem[RF_INADDRESS] <= RF_IN;
    end

    int n_applied;
    int n_miscompares;

    typedef struct {
        logic              rst;
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic [ADDR_W-1:0] rd1;
        logic [ADDR_W-1:0] rd2;
        logic              r0;
        logic              r1;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              h1;
        logic [DATA_W-1:0] f1;
        logic              h2;
        logic [DATA_W-1:0] f2;
        logic [CNT_W-1:0]  cnt;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input int rst, input int v0, input int a0, input int d0,
                                input int v1, input int a1, input int d1,
                                input int rd1, input int rd2,
                                input int r0, input int r1, input int we,
                                input int wa, input int wd,
                                input int h1, input int f1, input int h2, input int f2,
                                input int cnt);
        vec_t v;
        v.rst = 1'(rst); v.v0 = 1'(v0); v.a0 = 5'(a0); v.d0 = 32'(d0);
        v.v1 = 1'(v1); v.a1 = 5'(a1); v.d1 = 32'(d1);
        v.rd1 = 5'(rd1); v.rd2 = 5'(rd2);
        v.r0 = 1'(r0); v.r1 = 1'(r1); v.we = 1'(we);
        v.wa = 5'(wa); v.wd = 32'(wd);
        v.h1 = 1'(h1); v.f1 = 32'(f1); v.h2 = 1'(h2); v.f2 = 32'(f2);
        v.cnt = 4'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic v0, input int a0, input int d0,
                          input logic v1, input int a1, input int d1,
                          input int rd1, input int rd2);
        RESET      = rst;
        REQ0_VALID = v0;
        REQ0_ADDR  = 5'(a0);
        REQ0_DATA  = 32'(d0);
        REQ1_VALID = v1;
        REQ1_ADDR  = 5'(a1);
        REQ1_DATA  = 32'(d1);
        RD1_ADDR   = 5'(rd1);
        RD2_ADDR   = 5'(rd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_applied     = 0;
        n_miscompares = 0;

        //               rst v0 a0 d0   v1 a1 d1  rd1 rd2 | r0 r1 we wa wd   h1 f1   h2 f2   cnt
        vecs[0]  = mk(1, 1, 2, 95,  0, 0, 0,  2, 0,  0, 0, 0, 0, 0,   0, 0,   0, 0,   0);
        vecs[1]  = mk(0, 1, 2, 95,  0, 0, 0,  2, 0,  1, 0, 0, 0, 0,   0, 0,   0, 0,   0);
        vecs[2]  = mk(0, 0, 0, 0,   0, 0, 0,  2, 5,  0, 0, 1, 2, 95,  1, 95,  0, 0,   0);
        vecs[3]  = mk(0, 0, 0, 0,   0, 0, 0,  2, 2,  0, 0, 0, 2, 95,  0, 0,   0, 0,   0);
        vecs[4]  = mk(1, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 2, 95,  0, 0,   0, 0,   0);
        vecs[5]  = mk(0, 1, 1, 28,  1, 4, 6,  1, 4,  1, 0, 0, 0, 0,   0, 0,   0, 0,   0);
        vecs[6]  = mk(0, 1, 1, 28,  1, 4, 6,  1, 4,  0, 1, 1, 1, 28,  1, 28,  0, 0,   1);
        vecs[7]  = mk(0, 0, 0, 0,   0, 0, 0,  1, 4,  0, 0, 1, 4, 6,   0, 0,   1, 6,   2);
        vecs[8]  = mk(0, 1, 7, 9,   0, 0, 0,  7, 0,  1, 0, 0, 4, 6,   0, 0,   0, 0,   2);
        vecs[9]  = mk(0, 0, 0, 0,   1, 0, 50, 0, 7,  0, 1, 1, 7, 9,   0, 0,   1, 9,   2);
        vecs[10] = mk(0, 1, 6, 108, 1, 6, 15, 0, 7,  1, 0, 0, 7, 9,   0, 0,   0, 0,   2);
        vecs[11] = mk(0, 0, 0, 0,   1, 6, 15, 6, 6,  0, 1, 1, 6, 108, 1, 108, 1, 108, 3);
        vecs[12] = mk(0, 0, 0, 0,   0, 0, 0,  6, 0,  0, 0, 1, 6, 15,  1, 15,  0, 0,   3);
        vecs[13] = mk(0, 0, 0, 0,   0, 0, 0,  6, 0,  0, 0, 0, 6, 15,  0, 0,   0, 0,   3);

        // First reset cycle with requester 0 already pending.
        set_in(1, 1, 2, 95, 0, 0, 0, 2, 0);
        @(negedge CLK);
        #2 chk("pre.r0_in_reset", 32'(REQ0_READY), 0);
        @(negedge CLK);

        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].rst, vecs[i].v0, int'(vecs[i].a0), int'(vecs[i].d0),
                   vecs[i].v1, int'(vecs[i].a1), int'(vecs[i].d1),
                   int'(vecs[i].rd1), int'(vecs[i].rd2));
            #2;
            chk($sformatf("v%0d.r0", i),  32'(REQ0_READY),   32'(vecs[i].r0));
            chk($sformatf("v%0d.r1", i),  32'(REQ1_READY),   32'(vecs[i].r1));
            chk($sformatf("v%0d.we", i),  32'(RF_WRITE),     32'(vecs[i].we));
            chk($sformatf("v%0d.wa", i),  32'(RF_INADDRESS), 32'(vecs[i].wa));
            chk($sformatf("v%0d.wd", i),  RF_IN,             vecs[i].wd);
            chk($sformatf("v%0d.h1", i),  32'(FWD1_HIT),     32'(vecs[i].h1));
            chk($sformatf("v%0d.f1", i),  FWD1_DATA,         vecs[i].f1);
            chk($sformatf("v%0d.h2", i),  32'(FWD2_HIT),     32'(vecs[i].h2));
            chk($sformatf("v%0d.f2", i),  FWD2_DATA,         vecs[i].f2);
            chk($sformatf("v%0d.cnt", i), 32'(CONFLICT_CNT), 32'(vecs[i].cnt));
            @(negedge CLK);
        end

        // Register file contents after the table: later same-address write wins,
        // x0 was never written.
        chk("rf[2]", rf_mem[2], 95);
        chk("rf[1]", rf_mem[1], 28);
        chk("rf[4]", rf_mem[4], 6);
        chk("rf[7]", rf_mem[7], 9);
        chk("rf[6]", rf_mem[6], 15);
        chk("rf[0]", rf_mem[0], 0);

        // Saturation: both valid for 20 cycles from reset, grants alternate.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        set_in(0, 1, 3, 33, 1, 5, 55, 0, 0);
        for (int k = 0; k < 20; k++) begin
            #2;
            chk($sformatf("sat%0d.r0", k), 32'(REQ0_READY), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("sat%0d.r1", k), 32'(REQ1_READY), (k % 2 == 1) ? 1 : 0);
            if (k == 14) chk("sat14.cnt", 32'(CONFLICT_CNT), 14);
            @(negedge CLK);
        end
        #2 chk("sat.cnt_held", 32'(CONFLICT_CNT), 15);

        // Reset while a write to x4 is in the output register.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 1, 4, 15, 4, 0);
        #2 chk("rmw.r1", 32'(REQ1_READY), 1);
        @(negedge CLK);
        set_in(1, 1, 9, 99, 0, 0, 0, 4, 0);
        #2;
        chk("rmw.we_before", 32'(RF_WRITE), 1);
        chk("rmw.wa_before", 32'(RF_INADDRESS), 4);
        chk("rmw.wd_before", RF_IN, 15);
        chk("rmw.r0_in_reset", 32'(REQ0_READY), 0);
        @(negedge CLK);
        set_in(0, 1, 9, 99, 1, 10, 100, 4, 0);
        #2;
        chk("rmw.we_after", 32'(RF_WRITE), 0);
        chk("rmw.wa_after", 32'(RF_INADDRESS), 0);
        chk("rmw.h1_after", 32'(FWD1_HIT), 0);
        chk("rmw.rf4_kept", rf_mem[4], 6);
        chk("rmw.r0_first", 32'(REQ0_READY), 1);
        chk("rmw.r1_first", 32'(REQ1_READY), 0);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rmw.we_next", 32'(RF_WRITE), 1);
        chk("rmw.wa_next", 32'(RF_INADDRESS), 9);
        chk("rmw.wd_next", RF_IN, 99);
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
